puf_win_cntr: RTL and testbench
===============================

Name: puf_win_cntr

Overview:
- Multi-channel, windowed event counter for ring-oscillator PUF readout. Generalises the single fixed-threshold counter in three ways: N_CH channels, a programmable measurement window, and pairwise comparison that produces response bits.
- Sits between the oscillator-edge synchronisers, which deliver one-cycle clk-domain event strobes, and the PUF response collector/controller.

Parameters:
- N_CH, 4: number of event channels. Must be even and >= 2.
- CNT_W, 8: width of each per-channel event counter. Counters saturate at 2^CNT_W-1.
- WIN_LEN, 16: measurement window length in clk cycles. Must be >= 1.
- WIN_W, 5: window counter width. Must satisfy WIN_LEN <= 2^WIN_W-1.

Ports:
- clk  in  1  user clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_en  in  1  block enable. Low forces IDLE and aborts any window.
- i_start  in  1  start request. Sampled only in IDLE with i_en=1.
- i_cont  in  1  continuous mode. Starts back-to-back windows.
- i_evt  in  N_CH  per-channel event strobes, one count per high cycle.
- o_busy  out  1  high in RUN and DONE.
- o_valid  out  1  one-cycle pulse: result outputs updated.
- o_counts  out  N_CH*CNT_W  latched counts. Channel k occupies bits [k*CNT_W +: CNT_W].
- o_resp  out  N_CH/2  response bit j = (count[2j] > count[2j+1]).
- o_tie  out  N_CH/2  tie bit j = (count[2j] == count[2j+1]).
- o_sat  out  N_CH  channel k counter saturated during the window.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs, the window counter and the channel counters go to 0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN: when i_en=1 and i_start=1. Window counter and all channel counters are cleared on entry.
- In RUN:
  - Window counter increments every cycle.
  - Channel k increments in every RUN cycle where i_evt[k]=1, including the first and last RUN cycles.
  - Exactly WIN_LEN RUN cycles occur.
- RUN -> DONE: on the cycle where the window counter equals WIN_LEN-1.
  - On that clock edge, o_counts, o_resp, o_tie and o_sat are registered from the final counter values, including the last cycle's events.
- DONE lasts one cycle and o_valid=1 during it.
  - If i_cont=1 and i_en=1, next state is RUN with counters cleared.
  - Otherwise next state is IDLE.
- Latency: i_start sampled at edge t -> RUN cycles t+1..t+WIN_LEN -> o_valid high in cycle t+WIN_LEN+1.
- Continuous mode: o_valid pulses every WIN_LEN+1 cycles. The DONE cycle is dead time and its events are not counted.
- Saturation: a counter at 2^CNT_W-1 holds its value and sets its internal sat flag. The flag is cleared at window start.
- Comparison: unsigned. A tie gives resp=0 and tie=1.
- i_start is ignored while o_busy=1. There are no queued starts.
- i_en falling in RUN or DONE:
  - Next state is IDLE. Channel counters are cleared.
  - No o_valid is produced.
  - Result outputs hold their previous values.
- i_en=0 in IDLE: i_start is ignored.
- Clearing i_cont mid-window: the current window completes normally, then the block returns to IDLE.
- o_busy is a registered decode of state. It is 1 in the cycle after start is accepted.

Decomposition:
- Shared package/include puf_pkg holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default CNT_W and WIN_LEN constants, shared with the controller.
- Sub-module puf_evt_cntr: one saturating CNT_W counter with clear, increment enable and sat flag. Instantiated N_CH times through generate.
- FSM, window counter and compare/latch logic stay in puf_win_cntr.

Test Plan:
- Reset:
  - Assert rst_n=0 mid-RUN -> all outputs 0 immediately and state IDLE.
  - After release, with no start, o_busy stays 0.
- Basic window, defaults:
  - Start with ch0 strobing every cycle, ch1 every other cycle, ch2 for 3 pulses, ch3 for 5 pulses.
  - Expect o_valid at t+17, o_counts={5,3,8,16} (ch3..ch0), o_resp=2'b01, o_tie=2'b00, o_sat=0.
- Saturation, CNT_W=4:
  - 16 events on ch0 and 15 on ch1.
  - Expect counts 15 and 15, o_sat[1:0]=2'b11, o_tie[0]=1, o_resp[0]=0.
- Abort and ignored start:
  - Pulse i_start again during RUN -> no effect.
  - Drop i_en at RUN cycle 8 -> o_busy=0 next cycle, no o_valid, outputs keep the prior window's values.
- Continuous mode:
  - i_cont=1 with ch2 strobing constantly -> o_valid at t+17, t+34, t+51, count[2]=16 each time.
  - Clear i_cont during the third window -> IDLE after its DONE.
- Boundary WIN_LEN=1:
  - Start with an event on all channels in the single RUN cycle.
  - Expect o_valid at t+2, all counts 1, o_tie all 1.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared constants for the PUF readout path: FSM encodings and default
// counter/window sizes also used by the response controller.
package puf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } puf_state_e;

  localparam int PUF_N_CH    = 4;
  localparam int PUF_CNT_W   = 8;
  localparam int PUF_WIN_LEN = 16;
  localparam int PUF_WIN_W   = 5;

endpackage

// File: rtl/puf_evt_cntr.sv
// One saturating event counter with synchronous clear and a sticky flag that
// records the counter reaching its maximum value during the current window.
module puf_evt_cntr
  import puf_pkg::*;
#(
  parameter int CNT_W = PUF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt_nxt,
  output logic             o_sat_nxt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_sat_nxt;

  // Next values are exported so the parent can latch results that include
  // the events of the final window cycle.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_sat_nxt = r_sat;
    if (i_clr) begin
      w_cnt_nxt = '0;
      w_sat_nxt = 1'b0;
    end else begin
      if (i_inc && (r_cnt != CNT_MAX)) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
      w_sat_nxt = r_sat || (w_cnt_nxt == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_sat <= w_sat_nxt;
    end
  end

  assign o_cnt_nxt = w_cnt_nxt;
  assign o_sat_nxt = w_sat_nxt;

endmodule

// File: rtl/puf_win_cntr.sv
// Multi-channel windowed event counter for ring-oscillator PUF readout.
// Counts strobes per channel over a fixed window and compares channel pairs.
module puf_win_cntr
  import puf_pkg::*;
#(
  parameter int N_CH    = PUF_N_CH,
  parameter int CNT_W   = PUF_CNT_W,
  parameter int WIN_LEN = PUF_WIN_LEN,
  parameter int WIN_W   = PUF_WIN_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic                  i_start,
  input  logic                  i_cont,
  input  logic [N_CH-1:0]       i_evt,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [N_CH*CNT_W-1:0] o_counts,
  output logic [N_CH/2-1:0]     o_resp,
  output logic [N_CH/2-1:0]     o_tie,
  output logic [N_CH-1:0]       o_sat
);

  // Handshake: o_valid is a one-cycle strobe with no ready; results on
  // o_counts/o_resp/o_tie/o_sat are stable from that cycle until the next one.

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

  puf_state_e r_state;
  puf_state_e w_state_nxt;

  logic [WIN_W-1:0]      r_win;
  logic                  r_busy;
  logic                  r_valid;
  logic [N_CH*CNT_W-1:0] r_counts;
  logic [N_CH/2-1:0]     r_resp;
  logic [N_CH/2-1:0]     r_tie;
  logic [N_CH-1:0]       r_sat;

  logic                  w_win_last;
  logic                  w_win_start;
  logic                  w_done;
  logic                  w_clr;
  logic [N_CH-1:0]       w_inc;
  logic [N_CH*CNT_W-1:0] w_cnt_nxt;
  logic [N_CH-1:0]       w_sat_nxt;
  logic [N_CH/2-1:0]     w_resp;
  logic [N_CH/2-1:0]     w_tie;

  assign w_win_last = (r_win == WIN_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_en && i_start) w_state_nxt = RUN;
      end
      RUN: begin
        if (!i_en)           w_state_nxt = IDLE;
        else if (w_win_last) w_state_nxt = DONE;
      end
      DONE: begin
        if (i_en && i_cont) w_state_nxt = RUN;
        else                w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_win_start = (w_state_nxt == RUN) && (r_state != RUN);
  assign w_done      = (r_state == RUN) && (w_state_nxt == DONE);
  // Dropping i_en also discards partial counts of an aborted window.
  assign w_clr       = w_win_start || !i_en;
  assign w_inc       = {N_CH{r_state == RUN}} & i_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win <= '0;
    end else if (w_win_start) begin
      r_win <= '0;
    end else if (r_state == RUN) begin
      r_win <= r_win + 1'b1;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    puf_evt_cntr #(
      .CNT_W (CNT_W)
    ) u_cntr (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (w_clr),
      .i_inc     (w_inc[k]),
      .o_cnt_nxt (w_cnt_nxt[k*CNT_W +: CNT_W]),
      .o_sat_nxt (w_sat_nxt[k])
    );
  end

  always_comb begin
    w_resp = '0;
    w_tie  = '0;
    for (int j = 0; j < N_CH/2; j++) begin
      w_resp[j] = w_cnt_nxt[2*j*CNT_W +: CNT_W] > w_cnt_nxt[(2*j+1)*CNT_W +: CNT_W];
      w_tie[j]  = w_cnt_nxt[2*j*CNT_W +: CNT_W] == w_cnt_nxt[(2*j+1)*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_counts <= '0;
      r_resp   <= '0;
      r_tie    <= '0;
      r_sat    <= '0;
    end else begin
      r_busy  <= (w_state_nxt != IDLE);
      r_valid <= w_done;
      if (w_done) begin
        r_counts <= w_cnt_nxt;
        r_resp   <= w_resp;
        r_tie    <= w_tie;
        r_sat    <= w_sat_nxt;
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_valid  = r_valid;
  assign o_counts = r_counts;
  assign o_resp   = r_resp;
  assign o_tie    = r_tie;
  assign o_sat    = r_sat;

endmodule

// File: tb/tb_puf_win_cntr.sv
// Directed bench for puf_win_cntr: default build, a 4-bit counter build and a
// single-cycle window build share one set of stimulus inputs.
module tb_puf_win_cntr;
  import puf_pkg::*;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       i_en    = 1'b0;
  logic       i_start = 1'b0;
  logic       i_cont  = 1'b0;
  logic [3:0] i_evt   = 4'h0;

  logic        d_busy, d_valid;
  logic [31:0] d_counts;
  logic [1:0]  d_resp, d_tie;
  logic [3:0]  d_sat;

  logic        s_busy, s_valid;
  logic [15:0] s_counts;
  logic [1:0]  s_resp, s_tie;
  logic [3:0]  s_sat;

  logic        w_busy, w_valid;
  logic [31:0] w_counts;
  logic [1:0]  w_resp, w_tie;
  logic [3:0]  w_sat;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  puf_win_cntr dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_start(i_start), .i_cont(i_cont),
    .i_evt(i_evt), .o_busy(d_busy), .o_valid(d_valid), .o_counts(d_counts),
    .o_resp(d_resp), .o_tie(d_tie), .o_sat(d_sat)
  );

  puf_win_cntr #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_start(i_start), .i_cont(i_cont),
    .i_evt(i_evt), .o_busy(s_busy), .o_valid(s_valid), .o_counts(s_counts),
    .o_resp(s_resp), .o_tie(s_tie), .o_sat(s_sat)
  );

  puf_win_cntr #(.WIN_LEN(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_start(i_start), .i_cont(i_cont),
    .i_evt(i_evt), .o_busy(w_busy), .o_valid(w_valid), .o_counts(w_counts),
    .o_resp(w_resp), .o_tie(w_tie), .o_sat(w_sat)
  );

  // One clock edge, returning at the following falling edge where outputs are
  // sampled and new inputs are driven.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Event pattern for RUN cycle k (0-based) of a window.
  function automatic logic [3:0] pat_evt(input int pat, input int k);
    logic [3:0] e;
    e = 4'h0;
    case (pat)
      0: begin
        e[0] = 1'b1;
        e[1] = (k % 2 == 0);
        e[2] = (k < 3);
        e[3] = (k < 5);
      end
      1: begin
        e[0] = 1'b1;
        e[1] = (k < 15);
      end
      2: e[3] = 1'b1;
      default: e = 4'h0;
    endcase
    return e;
  endfunction

  task automatic start_win();
    i_start = 1'b1;
    i_evt   = 4'h0;
    step();
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++;
    if ({d_busy, d_valid, d_counts, d_resp, d_tie, d_sat} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b valid=%b counts=%h, required all 0",
               d_busy, d_valid, d_counts);
    end
    rst_n = 1'b1;
    i_en  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (d_busy !== 1'b0 || d_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle[%0d]: got busy=%b valid=%b, required 0 0", k, d_busy, d_valid);
      end
    end
  endtask

  task automatic test_basic();
    start_win();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (d_valid !== 1'b0 || d_busy !== 1'b1) begin
        failures++;
        $display("FAIL basic_run[%0d]: got valid=%b busy=%b, required 0 1", k, d_valid, d_busy);
      end
      i_evt = pat_evt(0, k);
      step();
    end
    i_evt = 4'h0;
    checks++;
    if (d_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_valid: got %b, required 1", d_valid);
    end
    checks++;
    if (d_counts !== 32'h05030810) begin
      failures++;
      $display("FAIL basic_counts: got %h, required 05030810", d_counts);
    end
    checks++;
    if (d_resp !== 2'b01 || d_tie !== 2'b00 || d_sat !== 4'h0) begin
      failures++;
      $display("FAIL basic_cmp: got resp=%b tie=%b sat=%b, required 01 00 0000",
               d_resp, d_tie, d_sat);
    end
    step();
    checks++;
    if (d_valid !== 1'b0 || d_busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_after: got valid=%b busy=%b, required 0 0", d_valid, d_busy);
    end
  endtask

  task automatic test_saturation();
    start_win();
    for (int k = 0; k < 16; k++) begin
      i_evt = pat_evt(1, k);
      step();
    end
    i_evt = 4'h0;
    checks++;
    if (s_valid !== 1'b1 || s_counts !== 16'h00FF) begin
      failures++;
      $display("FAIL sat_counts: got valid=%b counts=%h, required 1 00ff", s_valid, s_counts);
    end
    checks++;
    if (s_sat !== 4'b0011 || s_tie !== 2'b11 || s_resp !== 2'b00) begin
      failures++;
      $display("FAIL sat_flags: got sat=%b tie=%b resp=%b, required 0011 11 00",
               s_sat, s_tie, s_resp);
    end
    checks++;
    if (d_counts !== 32'h00000F10 || d_resp !== 2'b01 || d_tie !== 2'b10 || d_sat !== 4'h0) begin
      failures++;
      $display("FAIL sat_wide: got counts=%h resp=%b tie=%b sat=%b, required 00000f10 01 10 0000",
               d_counts, d_resp, d_tie, d_sat);
    end
    step();
    step();
  endtask

  task automatic test_ignored_start();
    start_win();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (d_valid !== 1'b0) begin
        failures++;
        $display("FAIL ign_early[%0d]: got valid=%b, required 0", k, d_valid);
      end
      i_start = (k == 5);
      i_evt   = pat_evt(2, k);
      step();
    end
    i_start = 1'b0;
    i_evt   = 4'h0;
    checks++;
    if (d_valid !== 1'b1 || d_counts !== 32'h10000000 || d_tie !== 2'b01 || d_resp !== 2'b00) begin
      failures++;
      $display("FAIL ign_result: got valid=%b counts=%h tie=%b resp=%b, required 1 10000000 01 00",
               d_valid, d_counts, d_tie, d_resp);
    end
    step();
    step();
    checks++;
    if (d_busy !== 1'b0) begin
      failures++;
      $display("FAIL ign_no_queue: got busy=%b, required 0", d_busy);
    end
  endtask

  task automatic test_abort();
    start_win();
    for (int k = 0; k < 8; k++) begin
      i_evt   = pat_evt(0, k);
      i_start = (k == 2);
      if (k == 7) i_en = 1'b0;
      step();
    end
    i_start = 1'b0;
    i_evt   = 4'h0;
    checks++;
    if (d_busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy: got %b, required 0", d_busy);
    end
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (d_valid !== 1'b0) begin
        failures++;
        $display("FAIL abort_valid[%0d]: got %b, required 0", k, d_valid);
      end
      step();
    end
    checks++;
    if (d_counts !== 32'h10000000 || d_tie !== 2'b01 || d_resp !== 2'b00) begin
      failures++;
      $display("FAIL abort_hold: got counts=%h tie=%b resp=%b, required 10000000 01 00",
               d_counts, d_tie, d_resp);
    end
    i_en = 1'b1;
    step();
  endtask

  task automatic test_en_low_idle();
    i_en    = 1'b0;
    i_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (d_busy !== 1'b0) begin
        failures++;
        $display("FAIL en_low_start[%0d]: got busy=%b, required 0", k, d_busy);
      end
    end
    i_start = 1'b0;
    i_en    = 1'b1;
    step();
  endtask

  task automatic test_continuous();
    logic [31:0] exp_cnt;
    for (int n = 0; n < 3; n++) exp_q.push_back(32'h00100000);
    i_cont = 1'b1;
    start_win();
    i_evt = 4'b0100;
    for (int k = 0; k < 56; k++) begin
      checks++;
      if (d_valid !== ((k == 16) || (k == 33) || (k == 50))) begin
        failures++;
        $display("FAIL cont_valid[%0d]: got %b", k, d_valid);
      end
      checks++;
      if (d_busy !== (k <= 50)) begin
        failures++;
        $display("FAIL cont_busy[%0d]: got %b, required %b", k, d_busy, (k <= 50));
      end
      if (d_valid === 1'b1 && exp_q.size() > 0) begin
        exp_cnt = exp_q.pop_front();
        checks++;
        if (d_counts !== exp_cnt || d_resp !== 2'b10 || d_tie !== 2'b01) begin
          failures++;
          $display("FAIL cont_result[%0d]: got counts=%h resp=%b tie=%b, required %h 10 01",
                   k, d_counts, d_resp, d_tie, exp_cnt);
        end
      end
      if (k == 40) i_cont = 1'b0;
      step();
    end
    i_evt = 4'h0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL cont_missing: got %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_win1();
    start_win();
    checks++;
    if (w_valid !== 1'b0 || w_busy !== 1'b1) begin
      failures++;
      $display("FAIL w1_run: got valid=%b busy=%b, required 0 1", w_valid, w_busy);
    end
    i_evt = 4'hF;
    step();
    i_evt = 4'h0;
    checks++;
    if (w_valid !== 1'b1 || w_counts !== 32'h01010101) begin
      failures++;
      $display("FAIL w1_counts: got valid=%b counts=%h, required 1 01010101", w_valid, w_counts);
    end
    checks++;
    if (w_tie !== 2'b11 || w_resp !== 2'b00 || w_sat !== 4'h0) begin
      failures++;
      $display("FAIL w1_cmp: got tie=%b resp=%b sat=%b, required 11 00 0000", w_tie, w_resp, w_sat);
    end
    step();
    checks++;
    if (w_valid !== 1'b0 || w_busy !== 1'b0) begin
      failures++;
      $display("FAIL w1_after: got valid=%b busy=%b, required 0 0", w_valid, w_busy);
    end
    for (int k = 0; k < 20; k++) step();
  endtask

  task automatic test_reset_mid_run();
    start_win();
    for (int k = 0; k < 6; k++) begin
      i_evt = pat_evt(0, k);
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({d_busy, d_valid, d_counts, d_resp, d_tie, d_sat} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got busy=%b counts=%h resp=%b tie=%b, required all 0",
               d_busy, d_counts, d_resp, d_tie);
    end
    checks++;
    if (dut.r_state !== IDLE) begin
      failures++;
      $display("FAIL rst_mid_state: got %0d, required %0d", dut.r_state, IDLE);
    end
    i_evt = 4'h0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (d_busy !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_idle[%0d]: got busy=%b, required 0", k, d_busy);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_saturation();
    test_ignored_start();
    test_abort();
    test_en_low_idle();
    test_continuous();
    test_win1();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
